// File: rtl/fsm_cmd_issuer.sv
// fsm_cmd_issuer: queues 2-bit command requests, issues each one to the
// 3-bit command FSM and waits for its state to match or for a timeout.
// An illegal request or an illegal FSM state sets a sticky error flag.
// Optional feature macro: FSM_ISSUER_STATS_EN adds fail_cnt, a saturating
// count of failed completions.
module fsm_cmd_issuer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_cmd,
    output logic       req_ready,
    output logic [2:0] user_input,
    input  logic [2:0] fsm_out,
    output logic       done_valid,
    output logic       done_ok,
    output logic       busy,
    output logic       err_illegal
`ifdef FSM_ISSUER_STATS_EN
    ,
    output logic [7:0] fail_cnt
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = 8;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [1:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;
    logic          bad_req;

    logic [1:0]    cmd_r;
    logic [1:0]    cmd_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [2:0]    user_input_nxt;
    logic          done_ok_nxt;
    logic          done_valid_nxt;
    logic          fsm_err;
    logic          fsm_bad;
    logic          fsm_match;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign req_ready = !full;
    assign accept    = req_valid && req_ready;
    assign push      = accept && (req_cmd != 2'd3);
    assign bad_req   = accept && (req_cmd == 2'd3);
    assign busy      = (state != ST_IDLE) || !empty;

    assign fsm_bad   = fsm_out[2] || (fsm_out[1:0] == 2'd3);
    assign fsm_match = (fsm_out == {1'b0, cmd_r});

    // Request FIFO pointers; the popped entry must already be stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Request FIFO storage.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= req_cmd;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; WAIT leaves on illegal state, match or timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!empty) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (fsm_bad || fsm_match || (timer == TIMER_LAST))
                          state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output and datapath next values per state.
    always_comb begin
        pop            = 1'b0;
        cmd_nxt        = cmd_r;
        user_input_nxt = user_input;
        timer_nxt      = timer;
        done_ok_nxt    = done_ok;
        fsm_err        = 1'b0;
        case (state)
            ST_IDLE: begin
                user_input_nxt = 3'h0;
                if (!empty) begin
                    pop     = 1'b1;
                    cmd_nxt = mem[rd_ptr[AW-1:0]];
                end
            end
            ST_ISSUE: begin
                user_input_nxt = {1'b0, cmd_r};
                timer_nxt      = '0;
            end
            ST_WAIT: begin
                timer_nxt = timer + TW'(1);
                if (fsm_bad) begin
                    fsm_err     = 1'b1;
                    done_ok_nxt = 1'b0;
                end else if (fsm_match) begin
                    done_ok_nxt = 1'b1;
                end else if (timer == TIMER_LAST) begin
                    done_ok_nxt = 1'b0;
                end
            end
            ST_DONE: begin
                user_input_nxt = 3'h0;
            end
            default: begin
                user_input_nxt = 3'h0;
            end
        endcase
        done_valid_nxt = (state_nxt == ST_DONE);
    end

    // Registered outputs and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r       <= 2'd0;
            timer       <= '0;
            user_input  <= 3'h0;
            done_ok     <= 1'b0;
            done_valid  <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            cmd_r      <= cmd_nxt;
            timer      <= timer_nxt;
            user_input <= user_input_nxt;
            done_ok    <= done_ok_nxt;
            done_valid <= done_valid_nxt;
            if (bad_req || fsm_err) err_illegal <= 1'b1;
        end
    end

`ifdef FSM_ISSUER_STATS_EN
    // Saturating count of completions reported with done_ok low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt <= 8'd0;
        end else if (done_valid_nxt && !done_ok_nxt && (fail_cnt != 8'hFF)) begin
            fail_cnt <= fail_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fsm_cmd_issuer.sv
// Bench for fsm_cmd_issuer: a driver queues expected completions, a negedge
// monitor retires them against done_valid and also plays the command FSM.
module tb_fsm_cmd_issuer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 8;

    localparam int M_MATCH = 0;
    localparam int M_STALL = 1;
    localparam int M_ILL   = 2;

    typedef struct {
        int         cmd;
        int         mode;
        logic [2:0] ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [1:0] req_cmd;
    logic       req_ready;
    logic [2:0] user_input;
    logic [2:0] fsm_out = 3'h0;
    logic       done_valid;
    logic       done_ok;
    logic       busy;
    logic       err_illegal;
`ifdef FSM_ISSUER_STATS_EN
    logic [7:0] fail_cnt;
`endif

    exp_t       exp_q[$];
    exp_t       cur;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         exp_err = 1'b0;
    int         exp_fail = 0;
    int         cyc = 0;
    int         t_start = 0;
    int         unexp_done = 0;
    logic [2:0] ui_last = 3'h0;
    logic [2:0] ui_prev = 3'h0;

    fsm_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_cmd(req_cmd),
        .req_ready(req_ready),
        .user_input(user_input),
        .fsm_out(fsm_out),
        .done_valid(done_valid),
        .done_ok(done_ok),
        .busy(busy),
        .err_illegal(err_illegal)
`ifdef FSM_ISSUER_STATS_EN
        ,
        .fail_cnt(fail_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int lat_of(input int mode);
        if (mode == M_MATCH) return 2;
        if (mode == M_STALL) return int'(TIMEOUT);
        return 1;
    endfunction

    // Monitor/scoreboard, followed by the behavioural command FSM.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (user_input != 3'h0 && ui_last == 3'h0) t_start = cyc;
            ui_last = user_input;
            if (done_valid) begin
                if (exp_q.size() == 0) begin
                    unexp_done++;
                    check("unexpected_done", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("done_ok", int'(done_ok), (cur.mode == M_MATCH) ? 1 : 0);
                    check("issued_cmd", int'(user_input), cur.cmd);
                    if (cur.mode == M_ILL) exp_err = 1'b1;
                    check("err_illegal", int'(err_illegal), int'(exp_err));
                    if (cur.cmd != 0) check("latency", cyc - t_start, lat_of(cur.mode));
`ifdef FSM_ISSUER_STATS_EN
                    if (cur.mode != M_MATCH && exp_fail < 255) exp_fail++;
                    check("fail_cnt", int'(fail_cnt), exp_fail);
`endif
                end
            end
        end else begin
            ui_last = 3'h0;
        end
        if (exp_q.size() != 0 && exp_q[0].mode == M_STALL)
            fsm_out = 3'((exp_q[0].cmd + 1) % 3);
        else if (exp_q.size() != 0 && exp_q[0].mode == M_ILL)
            fsm_out = exp_q[0].ill;
        else
            fsm_out = ui_prev;
        ui_prev = user_input;
    end

    // Offer one request (called at a negedge) and record it once accepted.
    task automatic send(input int c, input int mode, input logic [2:0] ill);
        exp_t e;
        int   k;
        req_valid = 1'b1;
        req_cmd   = 2'(c);
        k = 0;
        while (!req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            check("req_ready_wait", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (c == 3) begin
            exp_err = 1'b1;
        end else begin
            e.cmd  = c;
            e.mode = mode;
            e.ill  = ill;
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        check("idle_user_input", int'(user_input), 0);
        check("idle_busy", int'(busy), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        exp_err  = 1'b0;
        exp_fail = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[5];
        int u0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_cmd   = 2'd0;

        // Reset held for three cycles while inputs toggle
        repeat (3) begin
            @(negedge clk);
            req_valid = 1'($urandom);
            req_cmd   = 2'($urandom);
        end
        #1;
        check("rst_user_input", int'(user_input), 0);
        check("rst_done_valid", int'(done_valid), 0);
        check("rst_err", int'(err_illegal), 0);
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);

        // Single command, FSM follows one cycle later
        send(1, M_MATCH, 3'h0);
        drain();

        // Timeout with FSM stuck away from the target
        send(2, M_STALL, 3'h0);
        drain();

        // Illegal request: consumed, flags error, nothing issued
        send(3, M_MATCH, 3'h0);
        check("cmd3_err", int'(err_illegal), 1);
        check("cmd3_busy", int'(busy), 0);
        check("cmd3_user_input", int'(user_input), 0);
        repeat (4) @(negedge clk);
        check("cmd3_busy_later", int'(busy), 0);
        apply_reset();
        check("err_cleared", int'(err_illegal), 0);

        // Illegal FSM state during WAIT, then error must remain sticky
        send(1, M_ILL, 3'h5);
        drain();
        send(2, M_MATCH, 3'h0);
        drain();
        check("err_sticky", int'(err_illegal), 1);
        apply_reset();

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 3'($urandom_range(3, 7)));
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        drain();
        apply_reset();

        // Backpressure: five back-to-back requests while the FSM stalls
        seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 1; seq[4] = 2;
        for (int i = 0; i < 5; i++) send(seq[i], M_STALL, 3'h0);
        check("full_req_ready", int'(req_ready), 0);
        check("full_busy", int'(busy), 1);
        drain();

        // Reset in WAIT with three commands queued
        for (int i = 0; i < 4; i++) send((i % 2 == 0) ? 1 : 2, M_STALL, 3'h0);
        check("pre_reset_user_input", int'(user_input), 1);
        rst_n = 1'b0;
        exp_q.delete();
        exp_err  = 1'b0;
        exp_fail = 0;
        #1;
        check("midrst_user_input", int'(user_input), 0);
        check("midrst_done_valid", int'(done_valid), 0);
        check("midrst_req_ready", int'(req_ready), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_err", int'(err_illegal), 0);
`ifdef FSM_ISSUER_STATS_EN
        check("midrst_fail_cnt", int'(fail_cnt), 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        u0 = unexp_done;
        repeat (40) @(negedge clk);
        check("no_done_after_reset", unexp_done - u0, 0);
        check("post_reset_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
